// File: rtl/pcs_pkg.sv
// -----------------------------------------------------------------------------
// pcs_pkg
// Shared constants and types for the 64b/66b PCS transmit path: sync headers,
// XGMII control characters, 7-bit block control codes, block type fields, the
// transmit state enum and the block classification enum.
// No ports (package).
// -----------------------------------------------------------------------------
package pcs_pkg;

  localparam int DATA_WIDTH    = 64;
  localparam int CONTROL_WIDTH = 8;
  localparam int HEADER_WIDTH  = 2;
  localparam int BLOCK_WIDTH   = 66;

  // Sync headers, bit 0 is sent first
  localparam logic [HEADER_WIDTH-1:0] HDR_CTRL = 2'b01;
  localparam logic [HEADER_WIDTH-1:0] HDR_DATA = 2'b10;

  // XGMII control characters
  localparam logic [7:0] XG_START = 8'hFB;
  localparam logic [7:0] XG_TERM  = 8'hFD;
  localparam logic [7:0] XG_ERROR = 8'hFE;
  localparam logic [7:0] XG_SEQ   = 8'h9C;
  localparam logic [7:0] XG_IDLE  = 8'h07;
  localparam logic [7:0] XG_LPI   = 8'h06;

  // 7-bit control codes carried inside control blocks
  localparam logic [6:0] CC_IDLE  = 7'h00;
  localparam logic [6:0] CC_LPI   = 7'h06;
  localparam logic [6:0] CC_ERROR = 7'h1E;

  // Block type fields
  localparam logic [7:0] BTF_C = 8'h1E;
  localparam logic [7:0] BTF_S = 8'h78;

  typedef enum logic [1:0] {
    TX_INIT,
    TX_C,
    TX_D,
    TX_E
  } tx_state_t;

  typedef enum logic [2:0] {
    BLK_C,
    BLK_S,
    BLK_D,
    BLK_T,
    BLK_E
  } blk_type_t;

  // Terminate block type field for a terminate character in octet k
  function automatic logic [7:0] btf_term(input logic [2:0] k);
    logic [7:0] btf;
    case (k)
      3'd0:    btf = 8'h87;
      3'd1:    btf = 8'h99;
      3'd2:    btf = 8'hAA;
      3'd3:    btf = 8'hB4;
      3'd4:    btf = 8'hCC;
      3'd5:    btf = 8'hD2;
      3'd6:    btf = 8'hE1;
      default: btf = 8'hFF;
    endcase
    return btf;
  endfunction

  // Map an XGMII control character already known to be Idle/LPI/Error
  function automatic logic [6:0] xgmii_to_cc(input logic [7:0] ch);
    logic [6:0] cc;
    case (ch)
      XG_LPI:   cc = CC_LPI;
      XG_ERROR: cc = CC_ERROR;
      default:  cc = CC_IDLE;
    endcase
    return cc;
  endfunction

endpackage

// File: rtl/pcs_tx_lane_encoder.sv
// -----------------------------------------------------------------------------
// pcs_tx_lane_encoder
// One lane of the 64b/66b transmit encoder: classifies the registered 8-octet
// word, runs the transmit state machine, registers the coded 66-bit block and
// keeps a saturating count of EBLOCK_T emissions outside TX_INIT.
// Ports:
//   i_clk, i_rst_n  clock, async active-low reset
//   i_valid         registered word is valid this cycle (advance the lane)
//   i_clr           registered counter clear, wins over an increment
//   i_txd, i_txc    registered lane data / control flags
//   o_coded         66-bit block, bit 0 sent first
//   o_err           pulse when a counted EBLOCK_T is emitted
//   o_err_cnt       saturating error count
// -----------------------------------------------------------------------------
module pcs_tx_lane_encoder
  import pcs_pkg::*;
#(
  parameter int ERR_CNT_WIDTH = 16
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_valid,
  input  logic                     i_clr,
  input  logic [DATA_WIDTH-1:0]    i_txd,
  input  logic [CONTROL_WIDTH-1:0] i_txc,
  output logic [BLOCK_WIDTH-1:0]   o_coded,
  output logic                     o_err,
  output logic [ERR_CNT_WIDTH-1:0] o_err_cnt
);

  localparam logic [BLOCK_WIDTH-1:0] EBLOCK_T = {{8{CC_ERROR}}, BTF_C, HDR_CTRL};

  tx_state_t                r_state;
  tx_state_t                w_next_state;
  blk_type_t                w_type;
  logic [2:0]               w_term_k;
  logic                     w_ctrl_ok;
  logic                     w_tail_ok;
  logic [7:0]               w_mask;
  logic                     w_emit_err;
  logic                     w_count;
  logic [BLOCK_WIDTH-1:0]   w_block;
  logic [BLOCK_WIDTH-1:0]   r_coded;
  logic                     r_err;
  logic [ERR_CNT_WIDTH-1:0] r_err_cnt;

  // Classify the word. A terminate needs the control mask to start exactly at
  // the terminate octet and every octet after it to be Idle.
  always_comb begin
    w_type    = BLK_E;
    w_term_k  = '0;
    w_ctrl_ok = 1'b1;
    w_tail_ok = 1'b1;
    w_mask    = '0;
    for (int i = 0; i < 8; i++) begin
      if (i_txd[8*i +: 8] != XG_IDLE && i_txd[8*i +: 8] != XG_LPI &&
          i_txd[8*i +: 8] != XG_ERROR) begin
        w_ctrl_ok = 1'b0;
      end
    end
    if (i_txc == 8'h00) begin
      w_type = BLK_D;
    end else if (i_txc == 8'h01 && i_txd[7:0] == XG_START) begin
      w_type = BLK_S;
    end else if (i_txc == 8'hFF && w_ctrl_ok) begin
      w_type = BLK_C;
    end else begin
      for (int k = 0; k < 8; k++) begin
        w_mask    = 8'hFF << k;
        w_tail_ok = 1'b1;
        for (int j = 0; j < 8; j++) begin
          if (j > k && i_txd[8*j +: 8] != XG_IDLE) begin
            w_tail_ok = 1'b0;
          end
        end
        if (i_txc == w_mask && i_txd[8*k +: 8] == XG_TERM && w_tail_ok) begin
          w_type   = BLK_T;
          w_term_k = 3'(k);
        end
      end
    end
  end

  // Build the block for the classified word, ignoring protocol state
  always_comb begin
    w_block = '0;
    case (w_type)
      BLK_D: w_block = {i_txd, HDR_DATA};
      BLK_S: w_block = {i_txd[63:8], BTF_S, HDR_CTRL};
      BLK_C: begin
        w_block[1:0] = HDR_CTRL;
        w_block[9:2] = BTF_C;
        for (int i = 0; i < 8; i++) begin
          w_block[10+7*i +: 7] = xgmii_to_cc(i_txd[8*i +: 8]);
        end
      end
      BLK_T: begin
        w_block[1:0] = HDR_CTRL;
        w_block[9:2] = btf_term(w_term_k);
        for (int i = 0; i < 7; i++) begin
          if (i < int'(w_term_k)) begin
            w_block[10+8*i +: 8] = i_txd[8*i +: 8];
          end
        end
      end
      default: w_block = EBLOCK_T;
    endcase
  end

  // Transmit state machine: w_emit_err replaces the block with EBLOCK_T
  always_comb begin
    w_next_state = r_state;
    w_emit_err   = 1'b0;
    case (r_state)
      TX_INIT: begin
        case (w_type)
          BLK_C:   w_next_state = TX_C;
          BLK_S:   w_next_state = TX_D;
          default: w_emit_err   = 1'b1;
        endcase
      end
      TX_C: begin
        case (w_type)
          BLK_C:   w_next_state = TX_C;
          BLK_S:   w_next_state = TX_D;
          default: begin
            w_emit_err   = 1'b1;
            w_next_state = TX_E;
          end
        endcase
      end
      TX_D: begin
        case (w_type)
          BLK_D:   w_next_state = TX_D;
          BLK_T:   w_next_state = TX_C;
          default: begin
            w_emit_err   = 1'b1;
            w_next_state = TX_E;
          end
        endcase
      end
      default: begin
        case (w_type)
          BLK_C:   w_next_state = TX_C;
          BLK_S:   w_next_state = TX_D;
          BLK_D:   w_next_state = TX_D;
          BLK_T:   w_next_state = TX_C;
          default: begin
            w_emit_err   = 1'b1;
            w_next_state = TX_E;
          end
        endcase
      end
    endcase
    w_count = w_emit_err && (r_state != TX_INIT);
  end

  // State register, only moves on accepted words
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= TX_INIT;
    end else if (i_valid) begin
      r_state <= w_next_state;
    end
  end

  // Output register: block holds while the pipeline carries no word
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_coded <= '0;
      r_err   <= 1'b0;
    end else begin
      r_err <= i_valid && w_count;
      if (i_valid) begin
        r_coded <= w_emit_err ? EBLOCK_T : w_block;
      end
    end
  end

  // Saturating error counter, clear wins over increment
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_err_cnt <= '0;
    end else if (i_clr) begin
      r_err_cnt <= '0;
    end else if (i_valid && w_count && r_err_cnt != '1) begin
      r_err_cnt <= r_err_cnt + 1'b1;
    end
  end

  assign o_coded   = r_coded;
  assign o_err     = r_err;
  assign o_err_cnt = r_err_cnt;

endmodule

// File: rtl/pcs_tx_encoder.sv
// -----------------------------------------------------------------------------
// pcs_tx_encoder
// Multi-lane 64b/66b transmit encoder. Registers the XGMII-side word, then each
// lane encoder registers its 66-bit block; two cycles from input to output.
// Ports:
//   i_tx_clk, i_tx_rst_n  clock, async active-low reset
//   i_txd, i_tx_c         lane n at [64n +: 64] / [8n +: 8]
//   i_tx_valid            word valid; low stalls every lane
//   i_err_cnt_clr         clear all error counters
//   o_tx_coded            lane n block at [66n +: 66]
//   o_tx_coded_valid      o_tx_coded carries a new block
//   o_tx_err              per-lane EBLOCK_T pulse
//   o_err_cnt             per-lane saturating error counts
// -----------------------------------------------------------------------------
module pcs_tx_encoder
  import pcs_pkg::*;
#(
  parameter int LANES         = 2,
  parameter int ERR_CNT_WIDTH = 16
) (
  input  logic                             i_tx_clk,
  input  logic                             i_tx_rst_n,
  input  logic [DATA_WIDTH*LANES-1:0]      i_txd,
  input  logic [CONTROL_WIDTH*LANES-1:0]   i_tx_c,
  input  logic                             i_tx_valid,
  input  logic                             i_err_cnt_clr,
  output logic [BLOCK_WIDTH*LANES-1:0]     o_tx_coded,
  output logic                             o_tx_coded_valid,
  output logic [LANES-1:0]                 o_tx_err,
  output logic [ERR_CNT_WIDTH*LANES-1:0]   o_err_cnt
);

  logic [DATA_WIDTH*LANES-1:0]    r_txd;
  logic [CONTROL_WIDTH*LANES-1:0] r_txc;
  logic                           r_valid;
  logic                           r_clr;
  logic                           r_coded_valid;

  // Input register. The clear travels with the word it was issued alongside,
  // so a clear and an error on the same input cycle resolve to zero.
  always_ff @(posedge i_tx_clk or negedge i_tx_rst_n) begin
    if (!i_tx_rst_n) begin
      r_txd   <= '0;
      r_txc   <= '0;
      r_valid <= 1'b0;
      r_clr   <= 1'b0;
    end else begin
      r_valid <= i_tx_valid;
      r_clr   <= i_err_cnt_clr;
      if (i_tx_valid) begin
        r_txd <= i_txd;
        r_txc <= i_tx_c;
      end
    end
  end

  // Shared valid for the lane output registers
  always_ff @(posedge i_tx_clk or negedge i_tx_rst_n) begin
    if (!i_tx_rst_n) begin
      r_coded_valid <= 1'b0;
    end else begin
      r_coded_valid <= r_valid;
    end
  end

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    pcs_tx_lane_encoder #(
      .ERR_CNT_WIDTH(ERR_CNT_WIDTH)
    ) u_lane (
      .i_clk     (i_tx_clk),
      .i_rst_n   (i_tx_rst_n),
      .i_valid   (r_valid),
      .i_clr     (r_clr),
      .i_txd     (r_txd[g*DATA_WIDTH +: DATA_WIDTH]),
      .i_txc     (r_txc[g*CONTROL_WIDTH +: CONTROL_WIDTH]),
      .o_coded   (o_tx_coded[g*BLOCK_WIDTH +: BLOCK_WIDTH]),
      .o_err     (o_tx_err[g]),
      .o_err_cnt (o_err_cnt[g*ERR_CNT_WIDTH +: ERR_CNT_WIDTH])
    );
  end

  assign o_tx_coded_valid = r_coded_valid;

endmodule

// File: tb/tb_pcs_tx_encoder.sv
// -----------------------------------------------------------------------------
// tb_pcs_tx_encoder
// Scoreboard bench for pcs_tx_encoder: the stimulus side runs a table-driven
// reference model and queues expected blocks; a monitor pops and compares
// whenever the DUT presents a block, and checks the hold behaviour otherwise.
// -----------------------------------------------------------------------------
module tb_pcs_tx_encoder;

  localparam int LANES = 2;
  localparam int CW    = 2;
  localparam int CMAX  = (1 << CW) - 1;

  localparam int KC = 0, KS = 1, KD = 2, KT = 3, KE = 4;
  localparam int ST_INIT = 0;

  localparam logic [63:0] IDLE8    = 64'h0707070707070707;
  localparam logic [65:0] EBLK     = {{8{7'h1E}}, 8'h1E, 2'b01};
  localparam logic [65:0] IDLE_BLK = {56'h0, 8'h1E, 2'b01};

  typedef struct {
    logic [66*LANES-1:0] coded;
    logic [LANES-1:0]    err;
    logic [CW*LANES-1:0] cnt;
    longint              issue;
  } exp_t;

  logic                  clk = 1'b0;
  logic                  rstN = 1'b1;
  logic [64*LANES-1:0]   txd = '0;
  logic [8*LANES-1:0]    txc = '0;
  logic                  txValid = 1'b0;
  logic                  errClr = 1'b0;
  logic [66*LANES-1:0]   txCoded;
  logic                  txCodedValid;
  logic [LANES-1:0]      txErr;
  logic [CW*LANES-1:0]   errCnt;

  int     checks = 0;
  int     fails = 0;
  longint cycleCount = 0;
  bit     monOn = 1'b0;
  exp_t   sbQ[$];
  exp_t   monItem;
  logic [66*LANES-1:0] lastExpCoded = '0;

  // Reference model: state index by row, block kind by column
  int nextTab [4][5] = '{'{1,2,0,0,0}, '{1,2,3,3,3}, '{3,3,2,1,3}, '{1,2,2,1,3}};
  bit errTab  [4][5] = '{'{0,0,1,1,1}, '{0,0,1,1,1}, '{1,1,0,0,1}, '{0,0,0,0,1}};
  int btfTab  [8]    = '{'h87, 'h99, 'hAA, 'hB4, 'hCC, 'hD2, 'hE1, 'hFF};
  int mState [LANES];
  int mCnt   [LANES];

  pcs_tx_encoder #(
    .LANES(LANES),
    .ERR_CNT_WIDTH(CW)
  ) dut (
    .i_tx_clk         (clk),
    .i_tx_rst_n       (rstN),
    .i_txd            (txd),
    .i_tx_c           (txc),
    .i_tx_valid       (txValid),
    .i_err_cnt_clr    (errClr),
    .o_tx_coded       (txCoded),
    .o_tx_coded_valid (txCodedValid),
    .o_tx_err         (txErr),
    .o_err_cnt        (errCnt)
  );

  // Free-running clock and edge counter used for latency checks
  always #5 clk = ~clk;
  always @(posedge clk) cycleCount <= cycleCount + 1;

  // Compare helper shared by every check
  task automatic checkOutput(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Spec-level encoding of one lane word, independent of protocol state
  function automatic logic [65:0] modelEncode(input logic [63:0] d, input logic [7:0] c, output int kind);
    logic [7:0]  oct [8];
    logic [65:0] blk;
    bit ok;
    bit tail;
    int code;
    int mask;
    for (int i = 0; i < 8; i++) oct[i] = d[8*i +: 8];
    kind = KE;
    blk  = EBLK;
    if (c == 8'h00) begin
      kind = KD;
      blk  = {d, 2'b10};
    end else if (c == 8'h01 && oct[0] == 8'hFB) begin
      kind = KS;
      blk  = {d[63:8], 8'h78, 2'b01};
    end else begin
      ok = (c == 8'hFF);
      for (int i = 0; i < 8; i++)
        if (oct[i] != 8'h07 && oct[i] != 8'h06 && oct[i] != 8'hFE) ok = 1'b0;
      if (ok) begin
        kind = KC;
        blk  = (66'h1E << 2) | 66'd1;
        for (int i = 0; i < 8; i++) begin
          code = (oct[i] == 8'h06) ? 6 : (oct[i] == 8'hFE) ? 30 : 0;
          blk  = blk | (66'(code) << (10 + 7*i));
        end
      end else begin
        for (int t = 0; t < 8; t++) begin
          mask = (255 << t) & 255;
          tail = 1'b1;
          for (int j = t + 1; j < 8; j++) if (oct[j] != 8'h07) tail = 1'b0;
          if (c == 8'(mask) && oct[t] == 8'hFD && tail) begin
            kind = KT;
            blk  = (66'(btfTab[t]) << 2) | 66'd1;
            for (int i = 0; i < t; i++) blk = blk | (66'(oct[i]) << (10 + 8*i));
          end
        end
      end
    end
    return blk;
  endfunction

  // Drive one input cycle and queue what the model expects for it
  task automatic applyStimulus(input logic [127:0] d, input logic [15:0] c, input bit v,
                               input bit clr, input bit pin, input logic [65:0] pinBlk);
    exp_t        it;
    int          kind;
    logic [65:0] blk;
    bit          err;
    @(negedge clk);
    txd     = d;
    txc     = c;
    txValid = v;
    errClr  = clr;
    it.coded = '0;
    it.err   = '0;
    it.cnt   = '0;
    it.issue = cycleCount;
    for (int n = 0; n < LANES; n++) begin
      if (v) begin
        blk = modelEncode(d[64*n +: 64], c[8*n +: 8], kind);
        err = errTab[mState[n]][kind];
        if (err) blk = EBLK;
        if (err && mState[n] != ST_INIT) begin
          it.err[n] = 1'b1;
          if (mCnt[n] < CMAX) mCnt[n]++;
        end
        mState[n] = nextTab[mState[n]][kind];
        it.coded[66*n +: 66] = blk;
      end
      if (clr) mCnt[n] = 0;
      it.cnt[CW*n +: CW] = CW'(mCnt[n]);
    end
    if (v) begin
      if (pin) it.coded[65:0] = pinBlk;
      sbQ.push_back(it);
    end
  endtask

  // Lane 0 word with lane 1 idling, for the directed sequences
  task automatic lane0(input logic [63:0] d, input logic [7:0] c, input bit v,
                       input bit clr, input bit pin, input logic [65:0] pinBlk);
    applyStimulus({IDLE8, d}, {8'hFF, c}, v, clr, pin, pinBlk);
  endtask

  // Assert reset between edges, check outputs clear at once, then release
  task automatic applyReset();
    @(negedge clk);
    #2;
    rstN    = 1'b0;
    txValid = 1'b0;
    errClr  = 1'b0;
    sbQ.delete();
    lastExpCoded = '0;
    for (int n = 0; n < LANES; n++) begin
      mState[n] = ST_INIT;
      mCnt[n]   = 0;
    end
    #1;
    checkOutput("rst_coded", 256'(txCoded), 256'(0));
    checkOutput("rst_valid", 256'(txCodedValid), 256'(0));
    checkOutput("rst_err", 256'(txErr), 256'(0));
    checkOutput("rst_cnt", 256'(errCnt), 256'(0));
    @(negedge clk);
    #2;
    rstN  = 1'b1;
    monOn = 1'b1;
  endtask

  task automatic genLane(output logic [63:0] d, output logic [7:0] c);
    int r;
    int k;
    r = $urandom_range(0, 9);
    d = {$urandom, $urandom};
    c = 8'h00;
    case (r)
      0, 1, 2: begin
        c = 8'hFF;
        for (int i = 0; i < 8; i++) begin
          k = $urandom_range(0, 2);
          d[8*i +: 8] = (k == 0) ? 8'h07 : (k == 1) ? 8'h06 : 8'hFE;
        end
      end
      3: begin
        c = 8'h01;
        d[7:0] = 8'hFB;
      end
      4, 5, 6: c = 8'h00;
      7, 8: begin
        k = $urandom_range(0, 7);
        c = 8'((255 << k) & 255);
        d[8*k +: 8] = 8'hFD;
        for (int i = k + 1; i < 8; i++) d[8*i +: 8] = 8'h07;
      end
      default: c = 8'($urandom_range(1, 254));
    endcase
  endtask

  // Monitor: pop and compare on every presented block, check hold otherwise
  always @(negedge clk) begin
    if (monOn && rstN) begin
      if (txCodedValid) begin
        if (sbQ.size() == 0) begin
          checkOutput("unexpected_block", 256'(txCodedValid), 256'(0));
        end else begin
          monItem = sbQ.pop_front();
          checkOutput("coded", 256'(txCoded), 256'(monItem.coded));
          checkOutput("tx_err", 256'(txErr), 256'(monItem.err));
          checkOutput("err_cnt", 256'(errCnt), 256'(monItem.cnt));
          checkOutput("latency", 256'(cycleCount - monItem.issue), 256'(2));
          lastExpCoded = monItem.coded;
        end
      end else begin
        checkOutput("hold_coded", 256'(txCoded), 256'(lastExpCoded));
        checkOutput("idle_err", 256'(txErr), 256'(0));
      end
    end
  end

  initial begin
    logic [63:0] d0, d1;
    logic [7:0]  c0, c1;
    bit          v;
    bit          clr;

    $display("[TB] start");
    #1;
    applyReset();

    // Idle after reset, then S, D, T3
    repeat (3) lane0(IDLE8, 8'hFF, 1, 0, 1, IDLE_BLK);
    lane0(64'h77665544332211FB, 8'h01, 1, 0, 1, {56'h77665544332211, 8'h78, 2'b01});
    lane0(64'h0123456789ABCDEF, 8'h00, 1, 0, 1, {64'h0123456789ABCDEF, 2'b10});
    lane0(64'h07070707FDCCBBAA, 8'hF8, 1, 0, 1, {32'h0, 24'hCCBBAA, 8'hB4, 2'b01});
    lane0(IDLE8, 8'hFF, 1, 0, 1, IDLE_BLK);

    // Data without start, then recovery on Idle
    lane0(64'h1122334455667788, 8'h00, 1, 0, 1, EBLK);
    lane0(IDLE8, 8'hFF, 1, 0, 1, IDLE_BLK);

    // Saturation of the 2-bit counter, then clear together with an error
    lane0(64'hDEADBEEFCAFEF00D, 8'h00, 1, 0, 1, EBLK);
    repeat (4) lane0({$urandom, $urandom}, 8'h55, 1, 0, 1, EBLK);
    lane0({$urandom, $urandom}, 8'h55, 1, 1, 1, EBLK);
    lane0(IDLE8, 8'hFF, 1, 0, 1, IDLE_BLK);

    // Stall mid-packet: words offered with valid low must be ignored
    lane0(64'h77665544332211FB, 8'h01, 1, 0, 0, '0);
    lane0(64'hA5A5A5A5A5A5A5A5, 8'h00, 1, 0, 1, {64'hA5A5A5A5A5A5A5A5, 2'b10});
    lane0(64'h070707070707FD00, 8'hFF, 0, 0, 0, '0);
    lane0(64'h0000000000000000, 8'h55, 0, 0, 0, '0);
    lane0(64'h5A5A5A5A5A5A5A5A, 8'h00, 1, 0, 1, {64'h5A5A5A5A5A5A5A5A, 2'b10});
    lane0(64'h07070707070707FD, 8'hFF, 1, 0, 1, {56'h0, 8'h87, 2'b01});

    // Reset mid-packet, then EBLOCK_T until Idle
    lane0(64'h77665544332211FB, 8'h01, 1, 0, 0, '0);
    lane0(64'h0102030405060708, 8'h00, 1, 0, 0, '0);
    applyReset();
    lane0(64'h0102030405060708, 8'h00, 1, 0, 1, EBLK);
    lane0(64'h0102030405060708, 8'h33, 1, 0, 1, EBLK);
    lane0(IDLE8, 8'hFF, 1, 0, 1, IDLE_BLK);

    // Randomized traffic on both lanes
    for (int i = 0; i < 400; i++) begin
      genLane(d0, c0);
      genLane(d1, c1);
      v   = ($urandom_range(0, 99) < 85);
      clr = ($urandom_range(0, 99) < 3);
      applyStimulus({d1, d0}, {c1, c0}, v, clr, 0, '0);
    end

    // Drain the pipeline with bounded idle cycles
    for (int i = 0; i < 6; i++) applyStimulus('0, '0, 0, 0, 0, '0);
    checkOutput("sb_empty", 256'(sbQ.size()), 256'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/pcs_tx_encoder.md
# pcs_tx_encoder

Multi-lane 64b/66b transmit encoder for the PCS. It sits between the MAC-side XGMII-style interface (TXD/TX_C) and the scrambler/gearbox. It classifies each lane's 8-octet input, runs a per-lane transmit state machine, and emits 66-bit blocks or EBLOCK_T on protocol violations. It keeps saturating per-lane error counters and supports a stall qualifier from the downstream gearbox.

## Interface
- LANES, 2, number of independent 64-bit lanes
- ERR_CNT_WIDTH, 16, width of each per-lane error counter
- localparams: DATA_WIDTH=64, CONTROL_WIDTH=8, HEADER_WIDTH=2, BLOCK_WIDTH=66
- TX_CLK  in  1  sole clock, rising edge
- TX_RST_N  in  1  reset, asynchronous assert, active-low
- TXD  in  64*LANES  lane n = TXD[64n +: 64], octet i = bits [8i +: 8]
- TX_C  in  8*LANES  lane n control flags, bit i marks octet i as control
- TX_VALID  in  1  input word valid; low = stall, nothing sampled
- ERR_CNT_CLR  in  1  synchronous clear of all error counters
- TX_CODED  out  66*LANES  lane n block = TX_CODED[66n +: 66], bit 0 sent first
- TX_CODED_VALID  out  1  TX_CODED holds a new block this cycle
- TX_ERR  out  LANES  1-cycle pulse, aligned with TX_CODED_VALID, when the lane emits EBLOCK_T
- ERR_CNT  out  ERR_CNT_WIDTH*LANES  per-lane saturating count of EBLOCK_T emissions (excluding TX_INIT)

## Operation
- Block classification per lane, combinational, from registered input:
  - D: TX_C=8'h00.
  - S: TX_C=8'h01 and octet0=8'hFB.
  - C: TX_C=8'hFF and every octet is in {07 Idle, 06 LPI, FE Error}.
  - T_k (k=0..7): TX_C=8'hFF<<k, octet k=8'hFD, octets k+1..7 = 8'h07.
  - E: anything else.
- Encoding, header in [1:0]:
  - Control blocks: header=2'b01. Data blocks: header=2'b10.
  - D: [65:2]=TXD.
  - C: BTF 8'h1E in [9:2]; char i in [10+7i +: 7]: Idle→7'h00, LPI→7'h06, Error→7'h1E.
  - S: BTF 8'h78; [65:10]=TXD[63:8].
  - T_k: BTF = 87,99,AA,B4,CC,D2,E1,FF for k=0..7; [10 +: 8k]=octets 0..k-1; all higher bits 0.
  - EBLOCK_T: C-format block with all eight chars 7'h1E.
- State machine per lane, advancing only on accepted words (TX_VALID=1):
  - TX_INIT: emit EBLOCK_T; C→TX_C, S→TX_D, else stay.
  - TX_C: C→emit, stay; S→emit, TX_D; D/T/E→EBLOCK_T, TX_E.
  - TX_D: D→emit, stay; T→emit, TX_C; C/S/E→EBLOCK_T, TX_E.
  - TX_E: C→emit, TX_C; S or D→emit, TX_D; T→emit, TX_C; E→EBLOCK_T, stay.
- TX_INIT emissions do not pulse TX_ERR or count. Every other EBLOCK_T pulses TX_ERR[n] and increments ERR_CNT[n], saturating at all-ones.
- ERR_CNT_CLR takes priority over a simultaneous increment: the counter reads 0 next cycle.
- Lanes are fully independent; each has its own state.

## Timing
- Latency: 2 cycles, from TX_VALID=1 at edge N to TX_CODED/TX_CODED_VALID at edge N+2 (input register, then output register).
- TX_VALID low: no state advance. The valid pipeline carries 0, and TX_CODED holds its last value.
- Back-to-back TX_VALID=1 gives one block per cycle with no bubbles.
- Reset values: TX_CODED=0, TX_CODED_VALID=0, TX_ERR=0, ERR_CNT=0, all lane states TX_INIT, pipeline valids 0.
- Reset assertion mid-frame clears everything immediately. After deassertion the lane re-enters TX_INIT, so it emits EBLOCK_T until the first C or S.

## Structure
- Package pcs_pkg holds:
  - header constants (01/10);
  - XGMII chars (FB, FD, FE, 9C, 07, 06);
  - 7-bit control codes;
  - BTF constants;
  - the tx_state_t enum (TX_INIT, TX_C, TX_D, TX_E);
  - the blk_type_t enum (C, S, D, T, E).
- Sub-module pcs_tx_lane_encoder: one lane's classification, state machine, encoder and counter. The top level generates LANES copies and shares the valid pipeline.

## Test plan
- Reset, then lane 0 sends TX_C=FF, TXD=0707070707070707: the first block out is Idle with header 01, [9:2]=1E, [65:10]=0, TX_ERR=0, ERR_CNT=0.
- After idles, send S with TXD=0x77665544332211FB and TX_C=01: [1:0]=01, [9:2]=78, [65:10]=0x77665544332211, 2 cycles after input.
- Send D with TXD=0x0123456789ABCDEF, then T3 (TX_C=F8, TXD=0x07070707FDCCBBAA): the blocks are header 10 with the data passed through, then BTF B4 with [33:10]=0xCCBBAA and upper bits 0.
- From TX_C, send D without S: EBLOCK_T (BTF 1E, all chars 1E), TX_ERR[0] pulses for 1 cycle, ERR_CNT[0]=1. The next C returns lane 0 to normal Idle encoding while lane 1 stays unaffected.
- With ERR_CNT_WIDTH=2, force 5 errors: ERR_CNT[0] saturates at 3. Assert ERR_CNT_CLR together with a 6th error: the counter reads 0.
- TX_VALID toggles 1,0,0,1 mid-packet: exactly 2 blocks come out, TX_CODED holds during the gaps, and the state does not advance. Then assert TX_RST_N=0 mid-packet: all outputs read 0 at once, and after release the lane emits EBLOCK_T until an Idle arrives.
